// File: rtl/stream_demux.sv
// stream_demux: 1-to-OUT_NUM stream demultiplexer with a one-entry holding register per channel.
// Define STREAM_DEMUX_DROP_CNT_EN to add drop_cnt, a saturating count of out-of-range beats.
module stream_demux #(
   parameter int SEL_WIDTH  = 2,
   parameter int DATA_WIDTH = 8,
   parameter int OUT_NUM    = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [SEL_WIDTH-1:0]          in_sel,
   input  logic [DATA_WIDTH-1:0]         in_data,
   output logic [OUT_NUM-1:0]            out_valid,
   input  logic [OUT_NUM-1:0]            out_ready,
   output logic [OUT_NUM*DATA_WIDTH-1:0] out_data
`ifdef STREAM_DEMUX_DROP_CNT_EN
   ,
   output logic [7:0]                    drop_cnt
`endif
);

   if (OUT_NUM < 1 || OUT_NUM > (1 << SEL_WIDTH)) begin : g_cfg_error
      $error("stream_demux: OUT_NUM must lie in 1..2**SEL_WIDTH");
   end

   logic               sel_ready;
   logic               in_fire;
   logic [OUT_NUM-1:0] sel_hit;
   logic [OUT_NUM-1:0] wr_en;

   // A select that matches no channel leaves sel_ready at 1, so out-of-range beats are swallowed.
   always_comb begin
      // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
      sel_ready = 1'b1;
      sel_hit   = '0;
      for (int k = 0; k < OUT_NUM; k++) begin
         if (in_sel == SEL_WIDTH'(k)) begin
            sel_hit[k] = 1'b1;
            sel_ready  = !out_valid[k] || out_ready[k];
         end
      end
   end

   assign in_ready = rst_n && sel_ready;
   assign in_fire  = in_valid && in_ready;
   assign wr_en    = in_fire ? sel_hit : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the payload registers are reset as well, because out_data must read 0 out of reset.
         out_valid <= '0;
         out_data  <= '0;
      end else begin
         // NOTE: non-blocking updates, so every channel sees the same pre-edge state.
         for (int k = 0; k < OUT_NUM; k++) begin
            if (wr_en[k]) begin
               out_valid[k]                          <= 1'b1;
               out_data[k*DATA_WIDTH +: DATA_WIDTH] <= in_data;
            end else if (out_ready[k]) begin
               out_valid[k] <= 1'b0;
            end
         end
      end
   end

`ifdef STREAM_DEMUX_DROP_CNT_EN
   localparam logic [SEL_WIDTH:0] NUM_W = (SEL_WIDTH+1)'(OUT_NUM);

   logic in_range;
   assign in_range = {1'b0, in_sel} < NUM_W;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (in_fire && !in_range && drop_cnt != 8'hFF) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: directed scenarios plus random streaming against a queue model.
// A second instance with OUT_NUM=3 exercises out-of-range selects.
module tb_stream_demux;
   localparam int DW = 8;
   localparam int SW = 2;
   localparam int N  = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [SW-1:0] in_sel = '0;
   logic [DW-1:0] in_data = '0;
   logic [N-1:0]  out_ready = '0;
   logic          in_ready;
   logic [N-1:0]  out_valid;
   logic [N*DW-1:0] out_data;

   logic          in_valid3 = 1'b0;
   logic [SW-1:0] in_sel3 = '0;
   logic [DW-1:0] in_data3 = '0;
   logic [2:0]    out_ready3 = '0;
   logic          in_ready3;
   logic [2:0]    out_valid3;
   logic [3*DW-1:0] out_data3;
`ifdef STREAM_DEMUX_DROP_CNT_EN
   logic [7:0]    drop_cnt;
   logic [7:0]    drop_cnt3;
`endif

   stream_demux #(.SEL_WIDTH(SW), .DATA_WIDTH(DW), .OUT_NUM(N)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef STREAM_DEMUX_DROP_CNT_EN
      , .drop_cnt(drop_cnt)
`endif
   );

   stream_demux #(.SEL_WIDTH(SW), .DATA_WIDTH(DW), .OUT_NUM(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3), .in_sel(in_sel3),
      .in_data(in_data3), .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3)
`ifdef STREAM_DEMUX_DROP_CNT_EN
      , .drop_cnt(drop_cnt3)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: per-channel queue of accepted, not yet consumed beats.
   logic [DW-1:0] q[N][$];
   logic [DW-1:0] last_data[N];
   int  model_pops = 0;
   int  dut_pops = 0;
   int  accepted = 0;
   bit  check_en = 1'b0;

   function automatic logic exp_ready();
      if (!rst_n) return 1'b0;
      if (int'(in_sel) >= N) return 1'b1;
      return (q[in_sel].size() == 0) || out_ready[in_sel];
   endfunction

   always @(negedge rst_n) begin
      for (int k = 0; k < N; k++) begin
         q[k].delete();
         last_data[k] = '0;
      end
   end

   always @(posedge clk) begin
      if (rst_n) begin
         bit acc;
         acc = in_valid && exp_ready();
         for (int k = 0; k < N; k++) begin
            if (q[k].size() != 0 && out_ready[k]) begin
               last_data[k] = q[k].pop_front();
               model_pops++;
            end
         end
         if (acc && int'(in_sel) < N) begin
            q[in_sel].push_back(in_data);
            accepted++;
         end
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         logic [N-1:0]    ev;
         logic [N*DW-1:0] ed;
         for (int k = 0; k < N; k++) begin
            ev[k]          = q[k].size() != 0;
            ed[k*DW +: DW] = ev[k] ? q[k][0] : last_data[k];
         end
         check("model_in_ready", in_ready, exp_ready());
         check("model_out_valid", out_valid, ev);
         check("model_out_data", out_data, ed);
         if (rst_n) dut_pops += $countones(out_valid & out_ready);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit hold;
      for (int k = 0; k < N; k++) last_data[k] = '0;
      check_en = 1'b1;
      cyc();
      cyc();
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_out_valid", out_valid, 4'b0000);
      check("rst_out_data", out_data, 32'h0);

      // Single beat to channel 2, then a second beat that must stall.
      cyc(); in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5;
      @(negedge clk); check("t1_in_ready", in_ready, 1'b1);
      cyc(); in_data = 8'h5A;
      @(negedge clk);
      check("t1_out_valid", out_valid, 4'b0100);
      check("t1_out_data", out_data, 32'h00A5_0000);
      check("t1_stall", in_ready, 1'b0);
      cyc(); out_ready = 4'b0100;
      @(negedge clk); check("t1_refill_ready", in_ready, 1'b1);
      cyc(); in_valid = 1'b0;
      @(negedge clk);
      check("t1_refill_valid", out_valid, 4'b0100);
      check("t1_refill_data", out_data[23:16], 8'h5A);
      cyc(); out_ready = 4'b0000;
      @(negedge clk);
      check("t1_empty", out_valid, 4'b0000);
      check("t1_hold_data", out_data[23:16], 8'h5A);

      // Backpressure isolation: stalled channel 1 must not block channel 3.
      cyc(); in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h77;
      @(negedge clk); check("t2_ready_ch1", in_ready, 1'b1);
      cyc(); in_sel = 2'd3; in_data = 8'h11;
      @(negedge clk); check("t2_ready_ch3", in_ready, 1'b1);
      cyc(); in_valid = 1'b0;
      @(negedge clk);
      check("t2_out_valid", out_valid, 4'b1010);
      check("t2_ch1_data", out_data[15:8], 8'h77);
      check("t2_ch3_data", out_data[31:24], 8'h11);

      // Pass-through refill on channel 0.
      cyc(); in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h01;
      @(negedge clk); check("t3_first_ready", in_ready, 1'b1);
      cyc(); out_ready = 4'b0001; in_data = 8'h02;
      @(negedge clk);
      check("t3_full_before", out_valid[0], 1'b1);
      check("t3_refill_ready", in_ready, 1'b1);
      cyc(); in_valid = 1'b0; out_ready = 4'b0000;
      @(negedge clk);
      check("t3_out_valid", out_valid, 4'b1011);
      check("t3_ch0_data", out_data[7:0], 8'h02);

      // Asynchronous reset between edges with channels 0 and 2 full.
      cyc(); in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hC3;
      cyc(); in_valid = 1'b0;
      @(negedge clk); check("t5_all_full", out_valid, 4'b1111);
      cyc(); out_ready = 4'hF; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'hEE;
      #2; check("t5_ready_pre", in_ready, 1'b1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_valid", out_valid, 4'b0000);
      check("t5_rst_data", out_data, 32'h0);
      check("t5_rst_ready", in_ready, 1'b0);
      in_valid = 1'b0; out_ready = 4'b0000;
      cyc();
      cyc(); rst_n = 1'b1;
      @(negedge clk); check("t5_after_valid", out_valid, 4'b0000);

      // Out-of-range selects on the OUT_NUM=3 instance.
      cyc(); in_valid3 = 1'b1; in_sel3 = 2'd3;
      for (int i = 0; i < 3; i++) begin
         in_data3 = 8'($urandom);
         @(negedge clk);
         check("t4_oor_ready", in_ready3, 1'b1);
         check("t4_oor_valid", out_valid3, 3'b000);
         cyc();
      end
      in_valid3 = 1'b0;
      @(negedge clk);
      check("t4_oor_valid_end", out_valid3, 3'b000);
`ifdef STREAM_DEMUX_DROP_CNT_EN
      check("t4_drop_cnt3", drop_cnt3, 8'd3);
      check("t4_drop_cnt", drop_cnt, 8'd0);
`endif
      cyc(); in_valid3 = 1'b1; in_sel3 = 2'd0; in_data3 = 8'h3C;
      cyc(); in_valid3 = 1'b0;
      @(negedge clk);
      check("t4_inrange_valid", out_valid3, 3'b001);
      check("t4_inrange_data", out_data3[7:0], 8'h3C);

      // Random streaming; the per-cycle model compare covers order, loss and duplication.
      hold = 1'b0;
      for (int i = 0; i < 400; i++) begin
         cyc();
         if (!hold) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_sel   = 2'($urandom);
            in_data  = 8'($urandom);
         end
         out_ready = 4'($urandom);
         @(negedge clk);
         hold = in_valid && !in_ready;
      end
      cyc(); in_valid = 1'b0; out_ready = 4'hF;
      cyc();
      @(negedge clk);
      check("drain_empty", out_valid, 4'b0000);
      check("pop_count", 64'(dut_pops), 64'(model_pops));
      check("enough_beats", accepted >= 16, 1'b1);

      check_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Parameterized 1-to-N stream demultiplexer, the write-side counterpart of the parameterized mux.
- Routes each input beat (data + select) to one of OUT_NUM output channels.
- Each channel has a one-entry holding register and a valid/ready handshake.
- Sits between a single producer and up to 2**SEL_WIDTH independent consumers. Parameters are overridable per instance by #() or defparam.

Parameters:
- SEL_WIDTH, 2, width of in_sel.
- DATA_WIDTH, 8, width of one data beat.
- OUT_NUM, 4, number of output channels. Legal range 1..2**SEL_WIDTH; other values are a configuration error.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- in_valid  input  1  producer has a beat.
- in_ready  output  1  block accepts the beat this cycle.
- in_sel  input  SEL_WIDTH  destination channel index.
- in_data  input  DATA_WIDTH  beat payload.
- out_valid  output  OUT_NUM  per-channel holding register full.
- out_ready  input  OUT_NUM  per-channel consumer accept.
- out_data  output  OUT_NUM*DATA_WIDTH  flattened payloads; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid = 0 and out_data = 0 for all channels.
  - in_ready is forced 0 while rst_n is low.
  - Operation starts on the first clk edge after rst_n deasserts.
- Channel state: each channel k is EMPTY (out_valid[k]=0) or FULL (out_valid[k]=1).
- Handshakes:
  - Input transfer occurs when in_valid && in_ready at a rising edge.
  - Output transfer on channel k occurs when out_valid[k] && out_ready[k].
- in_ready, combinational:
  - in_sel < OUT_NUM: in_ready = !out_valid[in_sel] || out_ready[in_sel].
  - in_sel >= OUT_NUM: in_ready = 1 (beat accepted and discarded).
  - in_ready must not depend on in_valid.
- Latency: an accepted beat appears on out_data[in_sel] with out_valid set at the next edge, i.e. 1 cycle.
- Transitions for channel k:
  - EMPTY -> FULL on an input transfer with in_sel==k.
  - FULL -> EMPTY on an output transfer with no simultaneous input to k.
  - FULL -> FULL with the new data on a simultaneous output transfer and input transfer to k (pass-through refill, no bubble).
  - FULL with out_ready[k]=0 holds data and valid stable. in_ready stays 0 while in_sel==k.
- Isolation: channels are independent. A stalled channel never blocks beats addressed to other channels.
- out_data[k] holds its last value after it is consumed. Only out_valid[k] qualifies it.
- Out-of-range in_sel (possible when OUT_NUM < 2**SEL_WIDTH): the beat is dropped and no out_valid changes.
- Mid-operation reset: all held beats are lost immediately (asynchronous). No partial state survives.
- Protocol rule: in_valid/in_sel/in_data must stay stable while in_valid && !in_ready. The block does not check this.

Optional Feature:
- Macro STREAM_DEMUX_DROP_CNT_EN.
- Defined:
  - Adds output port drop_cnt, 8 bits, reset 0.
  - Increments by 1 at each accepted beat with in_sel >= OUT_NUM.
  - Saturates at 255. Cleared only by reset.
- Undefined: no drop_cnt port, and out-of-range beats are dropped silently. All other behaviour is identical.

Test Plan:
- Reset then single beat: in_sel=2, in_data=8'hA5, all out_ready=0 -> next cycle out_valid=4'b0100, out_data[2]=8'hA5, others 0. A second beat to sel 2 sees in_ready=0.
- Backpressure isolation: channel 1 FULL with out_ready[1]=0, then send 8'h11 to sel 3 -> in_ready=1 and out_valid=4'b1010. Channel 1 data unchanged.
- Pass-through refill: channel 0 FULL with 8'h01, out_ready[0]=1, in_valid with sel 0 and 8'h02 in the same cycle -> in_ready=1, next cycle out_valid[0]=1, out_data[0]=8'h02, no empty cycle.
- Out-of-range: override OUT_NUM=3, SEL_WIDTH=2 via defparam, send sel=3 three times -> in_ready=1, out_valid stays 3'b000. With STREAM_DEMUX_DROP_CNT_EN, drop_cnt=3.
- Async reset mid-operation: channels 0 and 2 FULL, pull rst_n low between edges -> out_valid=0, out_data=0 and in_ready=0 immediately, before the next clk edge.
- Streaming: 16 random beats with random sel and random out_ready -> a scoreboard shows per-channel order preserved and no loss or duplication for in-range beats.
